// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the ALU instruction sequencer: opcode
//            values, ALU function selects, sequencer state type and the
//            instruction-length helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Instruction opcodes (instruction byte bits [7:4])
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LDI  = 4'b0001;
  localparam logic [3:0] OP_JMP  = 4'b0010;
  localparam logic [3:0] OP_JC   = 4'b0011;
  localparam logic [3:0] OP_OUT  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_JZ   = 4'b0111;
  localparam logic [3:0] OP_ADD  = 4'b1001;
  localparam logic [3:0] OP_AND  = 4'b1011;
  localparam logic [3:0] OP_MOV  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // ALU function selects
  localparam logic [3:0] SE_ADD   = 4'b1001;
  localparam logic [3:0] SE_SUB   = 4'b0110;
  localparam logic [3:0] SE_AND   = 4'b1011;
  localparam logic [3:0] SE_NOT   = 4'b0101;
  localparam logic [3:0] SE_PASSD = 4'b0100;
  localparam logic [3:0] SE_PASSS = 4'b1100;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_OPER   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Instructions that carry an operand byte at PC+1
  function automatic logic is_two_byte(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JC) || (op == OP_JZ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_regfile.sv
`default_nettype none
// ============================================================================
// Module   : seq_regfile
// Purpose  : 4 x 8-bit register file, two asynchronous read ports and one
//            synchronous write port, synchronous active-low clear.
// Ports    : clk, rst_n            - clock / synchronous active-low reset
//            i_we, i_waddr, i_wdata - write port
//            i_raddr_a/o_rdata_a    - read port A
//            i_raddr_b/o_rdata_b    - read port B
// Revision : 1.0 - initial release
// ============================================================================
module seq_regfile (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_we,
  input  logic [1:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [1:0] i_raddr_a,
  output logic [7:0] o_rdata_a,
  input  logic [1:0] i_raddr_b,
  output logic [7:0] o_rdata_b
);

  logic [7:0] r_regs [4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Reads see the pre-write value, so rd==rs uses the old operand
  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Purpose  : Instruction sequencer in front of the 8-bit ALU. Fetches from a
//            synchronous program ROM, decodes, drives the ALU, writes results
//            back to a 4x8 register file and latches carry/zero flags.
// Ports    : clk, rst_n         - clock / synchronous active-low reset
//            run                - advance enable (sampled in FETCH only)
//            rom_addr, rom_data - program ROM (data valid one cycle later)
//            alu_M/se/S/D       - ALU mode, select and operands
//            alu_T/Cf/Zf        - ALU result and flags
//            flag_c, flag_z     - latched flags
//            out_port, out_stb  - output register and its load pulse
//            halted             - high in the HALT state
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic [PC_W-1:0] rom_addr,
  input  logic [7:0]      rom_data,
  output logic            alu_M,
  output logic [3:0]      alu_se,
  output logic [7:0]      alu_S,
  output logic [7:0]      alu_D,
  input  logic [7:0]      alu_T,
  input  logic            alu_Cf,
  input  logic            alu_Zf,
  output logic            flag_c,
  output logic            flag_z,
  output logic [7:0]      out_port,
  output logic            out_stb,
  output logic            halted
);

  state_t          r_state;
  state_t          w_next_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_target;
  logic [7:0]      r_ir;
  logic [3:0]      w_op;
  logic [1:0]      w_rd;
  logic [1:0]      w_rs;
  logic [7:0]      w_rs_val;
  logic [7:0]      w_rd_val;
  logic            w_rf_we;
  logic            w_flag_we;
  logic            w_out_load;
  logic            r_flag_c;
  logic            r_flag_z;
  logic [7:0]      r_out_port;
  logic            r_out_stb;

  assign w_op        = r_ir[7:4];
  assign w_rd        = r_ir[3:2];
  assign w_rs        = r_ir[1:0];
  assign w_pc_inc    = r_pc + PC_W'(1);
  assign w_pc_target = PC_W'(rom_data);

  seq_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_rf_we),
    .i_waddr   (w_rd),
    .i_wdata   (alu_T),
    .i_raddr_a (w_rs),
    .o_rdata_a (w_rs_val),
    .i_raddr_b (w_rd),
    .o_rdata_b (w_rd_val)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    alu_M        = 1'b0;
    alu_se       = 4'b0000;
    alu_S        = 8'h00;
    alu_D        = 8'h00;
    w_rf_we      = 1'b0;
    w_flag_we    = 1'b0;
    w_out_load   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (run) begin
          w_next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // rom_data holds the instruction byte addressed during FETCH
        w_pc_next    = w_pc_inc;
        w_next_state = is_two_byte(rom_data[7:4]) ? ST_OPER : ST_EXEC;
      end
      ST_OPER: begin
        w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        w_next_state = (w_op == OP_HALT) ? ST_HALT : ST_FETCH;
        case (w_op)
          OP_ADD, OP_SUB, OP_AND: begin
            alu_M     = 1'b1;
            alu_se    = (w_op == OP_ADD) ? SE_ADD : (w_op == OP_SUB) ? SE_SUB : SE_AND;
            alu_S     = w_rs_val;
            alu_D     = w_rd_val;
            w_rf_we   = 1'b1;
            w_flag_we = 1'b1;
          end
          OP_NOT: begin
            alu_M   = 1'b1;
            alu_se  = SE_NOT;
            alu_D   = w_rd_val;
            w_rf_we = 1'b1;
          end
          OP_MOV: begin
            alu_M   = 1'b1;
            alu_se  = SE_PASSS;
            alu_S   = w_rs_val;
            w_rf_we = 1'b1;
          end
          OP_OUT: begin
            alu_M      = 1'b1;
            alu_se     = SE_PASSD;
            alu_D      = w_rd_val;
            w_out_load = 1'b1;
          end
          // Two-byte ops: PC points at the operand, rom_data holds it now
          OP_LDI: begin
            alu_S     = rom_data;
            w_rf_we   = 1'b1;
            w_pc_next = w_pc_inc;
          end
          OP_JMP: w_pc_next = w_pc_target;
          OP_JC:  w_pc_next = r_flag_c ? w_pc_target : w_pc_inc;
          OP_JZ:  w_pc_next = r_flag_z ? w_pc_target : w_pc_inc;
          default: ;
        endcase
      end
      ST_HALT: begin
        w_next_state = ST_HALT;
      end
      default: begin
        w_next_state = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_ir       <= 8'h00;
      r_flag_c   <= 1'b0;
      r_flag_z   <= 1'b0;
      r_out_port <= 8'h00;
      r_out_stb  <= 1'b0;
    end else begin
      r_pc      <= w_pc_next;
      r_out_stb <= w_out_load;
      if (r_state == ST_DECODE) begin
        r_ir <= rom_data;
      end
      if (w_flag_we) begin
        r_flag_c <= alu_Cf;
        r_flag_z <= alu_Zf;
      end
      if (w_out_load) begin
        r_out_port <= alu_T;
      end
    end
  end

  assign rom_addr = r_pc;
  assign flag_c   = r_flag_c;
  assign flag_z   = r_flag_z;
  assign out_port = r_out_port;
  assign out_stb  = r_out_stb;
  assign halted   = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_ctrl
// Purpose  : Self-checking bench for alu_seq_ctrl with a behavioural ALU,
//            a synchronous program ROM and an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [7:0] rom_addr, rom_data;
  logic       alu_M;
  logic [3:0] alu_se;
  logic [7:0] alu_S, alu_D, alu_T;
  logic       alu_Cf, alu_Zf;
  logic       flag_c, flag_z;
  logic [7:0] out_port;
  logic       out_stb, halted;

  logic [7:0] rom [256];

  // Instruction-level reference state
  logic [7:0] m_pc, m_out;
  logic [7:0] m_r [4];
  logic       m_c, m_z, m_halt;

  int n_chk  = 0;
  int n_fail = 0;

  alu_seq_ctrl #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .alu_M(alu_M), .alu_se(alu_se), .alu_S(alu_S), .alu_D(alu_D),
    .alu_T(alu_T), .alu_Cf(alu_Cf), .alu_Zf(alu_Zf),
    .flag_c(flag_c), .flag_z(flag_z),
    .out_port(out_port), .out_stb(out_stb), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  // Behavioural ALU
  always_comb begin
    alu_T  = alu_S;
    alu_Cf = 1'b0;
    if (alu_M) begin
      case (alu_se)
        4'b1001: {alu_Cf, alu_T} = {1'b0, alu_D} + {1'b0, alu_S};
        4'b0110: {alu_Cf, alu_T} = {1'b0, alu_D} - {1'b0, alu_S};
        4'b1011: alu_T = alu_D & alu_S;
        4'b0101: alu_T = ~alu_D;
        4'b0100: alu_T = alu_D;
        4'b1100: alu_T = alu_S;
        default: alu_T = 8'h00;
      endcase
    end
    alu_Zf = !alu_Cf && (alu_T == 8'h00);
  end

  task automatic model_init();
    m_pc = 8'h00; m_out = 8'h00; m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
  endtask

  // Executes one instruction; entered and left at a negedge in FETCH.
  task automatic step(input int idle);
    logic [7:0] ir, opnd, s, d, pc_exp;
    logic [3:0] op;
    logic [1:0] rd, rs;
    logic       two, stb_exp;
    logic [8:0] wide;
    ir = rom[m_pc]; op = ir[7:4]; rd = ir[3:2]; rs = ir[1:0];
    opnd = rom[m_pc + 8'd1];
    two = (op == 4'h1) || (op == 4'h2) || (op == 4'h3) || (op == 4'h7);
    s = m_r[rs]; d = m_r[rd];
    pc_exp = m_pc + 8'd1; stb_exp = 1'b0;
    run = 1'b0;
    for (int i = 0; i < idle; i++) begin
      @(posedge clk); @(negedge clk);
      n_chk++;
      if ({rom_addr, out_stb, halted} !== {m_pc, 2'b00}) begin
        n_fail++;
        $display("FAIL run_hold: addr=%h stb=%b halt=%b, want addr=%h stb=0 halt=0", rom_addr, out_stb, halted, m_pc);
      end
    end
    run = 1'b1;
    n_chk++;
    if ({rom_addr, flag_c, flag_z, out_port, halted} !== {m_pc, m_c, m_z, m_out, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_state: addr=%h c=%b z=%b out=%h halt=%b, want %h %b %b %h 0",
               rom_addr, flag_c, flag_z, out_port, halted, m_pc, m_c, m_z, m_out);
    end
    @(posedge clk); @(negedge clk); run = 1'($urandom_range(0, 1));
    n_chk++;
    if ({alu_M, alu_se, alu_S, alu_D, out_stb, halted} !== 23'd0) begin
      n_fail++;
      $display("FAIL decode_idle: M=%b se=%h S=%h D=%h stb=%b halt=%b, want all 0", alu_M, alu_se, alu_S, alu_D, out_stb, halted);
    end
    if (two) begin
      @(posedge clk); @(negedge clk); run = 1'($urandom_range(0, 1));
      n_chk++;
      if ({rom_addr, alu_M, alu_se, alu_S, alu_D} !== {m_pc + 8'd1, 21'd0}) begin
        n_fail++;
        $display("FAIL oper_state: addr=%h M=%b se=%h S=%h D=%h, want addr=%h rest 0", rom_addr, alu_M, alu_se, alu_S, alu_D, m_pc + 8'd1);
      end
    end
    @(posedge clk); @(negedge clk); run = 1'($urandom_range(0, 1));
    n_chk++;
    if ({rom_addr, halted} !== {m_pc + 8'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL exec_pc: addr=%h halt=%b, want %h 0", rom_addr, halted, m_pc + 8'd1);
    end
    case (op)
      4'h9, 4'h6, 4'hB: begin
        n_chk++;
        if ({alu_M, alu_se, alu_S, alu_D} !== {1'b1, op, s, d}) begin
          n_fail++;
          $display("FAIL exec_arith op=%h: M=%b se=%h S=%h D=%h, want 1 %h %h %h", op, alu_M, alu_se, alu_S, alu_D, op, s, d);
        end
        if (op == 4'h9)      wide = {1'b0, d} + {1'b0, s};
        else if (op == 4'h6) wide = {1'b0, d} - {1'b0, s};
        else                 wide = {1'b0, d & s};
        m_r[rd] = wide[7:0]; m_c = wide[8]; m_z = (wide == 9'd0);
      end
      4'h5, 4'h4: begin
        n_chk++;
        if ({alu_M, alu_se, alu_D} !== {1'b1, op, d}) begin
          n_fail++;
          $display("FAIL exec_unary op=%h: M=%b se=%h D=%h, want 1 %h %h", op, alu_M, alu_se, alu_D, op, d);
        end
        if (op == 4'h5) m_r[rd] = ~d;
        else begin m_out = d; stb_exp = 1'b1; end
      end
      4'hC: begin
        n_chk++;
        if ({alu_M, alu_se, alu_S} !== {1'b1, 4'hC, s}) begin
          n_fail++;
          $display("FAIL exec_mov: M=%b se=%h S=%h, want 1 c %h", alu_M, alu_se, alu_S, s);
        end
        m_r[rd] = s;
      end
      4'h1: begin
        n_chk++;
        if ({alu_M, alu_S} !== {1'b0, opnd}) begin
          n_fail++;
          $display("FAIL exec_ldi: M=%b S=%h, want 0 %h", alu_M, alu_S, opnd);
        end
        m_r[rd] = opnd; pc_exp = m_pc + 8'd2;
      end
      4'h2: pc_exp = opnd;
      4'h3: pc_exp = m_c ? opnd : m_pc + 8'd2;
      4'h7: pc_exp = m_z ? opnd : m_pc + 8'd2;
      4'hF: m_halt = 1'b1;
      default: ;
    endcase
    @(posedge clk); @(negedge clk);
    m_pc = pc_exp;
    n_chk++;
    if ({rom_addr, flag_c, flag_z, out_port, out_stb, halted} !== {m_pc, m_c, m_z, m_out, stb_exp, m_halt}) begin
      n_fail++;
      $display("FAIL after_exec op=%h: addr=%h c=%b z=%b out=%h stb=%b halt=%b, want %h %b %b %h %b %b",
               op, rom_addr, flag_c, flag_z, out_port, out_stb, halted, m_pc, m_c, m_z, m_out, stb_exp, m_halt);
    end
  endtask

  task automatic test_reset();
    clear_rom();
    do_reset();
    n_chk++;
    if ({rom_addr, flag_c, flag_z, out_port, out_stb, halted} !== {8'h00, 12'd0}) begin
      n_fail++;
      $display("FAIL reset_state: addr=%h c=%b z=%b out=%h stb=%b halt=%b, want 00 0 0 00 0 0", rom_addr, flag_c, flag_z, out_port, out_stb, halted);
    end
    n_chk++;
    if ({alu_M, alu_se, alu_S, alu_D} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_alu_drive: M=%b se=%h S=%h D=%h, want all 0", alu_M, alu_se, alu_S, alu_D);
    end
  endtask

  task automatic test_run_hold();
    clear_rom();
    do_reset();
    step(5);   // NOP after five held FETCH cycles
    step(0);
  endtask

  task automatic test_program();
    clear_rom();
    rom[8'h00] = 8'h00;                         // NOP
    rom[8'h01] = 8'h70; rom[8'h02] = 8'h50;     // JZ 50
    rom[8'h03] = 8'h10; rom[8'h04] = 8'h05;     // LDI R0,05
    rom[8'h05] = 8'h14; rom[8'h06] = 8'hFB;     // LDI R1,FB
    rom[8'h07] = 8'h94;                         // ADD R1,R0
    rom[8'h08] = 8'h30; rom[8'h09] = 8'h20;     // JC 20
    rom[8'h20] = 8'h6A;                         // SUB R2,R2
    rom[8'h21] = 8'h70; rom[8'h22] = 8'h40;     // JZ 40
    rom[8'h40] = 8'h30; rom[8'h41] = 8'h60;     // JC 60 (not taken)
    rom[8'h42] = 8'h1C; rom[8'h43] = 8'h3C;     // LDI R3,3C
    rom[8'h44] = 8'h5C;                         // NOT R3
    rom[8'h45] = 8'h4C;                         // OUT R3
    rom[8'h46] = 8'h20; rom[8'h47] = 8'hFF;     // JMP FF
    rom[8'hFF] = 8'h00;                         // NOP, PC wraps
    rom[8'h50] = 8'hF0;                         // HALT
    do_reset();
    for (int i = 0; i < 5; i++) step(0);        // through ADD
    n_chk++;
    if ({flag_c, flag_z} !== 2'b10) begin
      n_fail++;
      $display("FAIL add_flags: c=%b z=%b, want 1 0", flag_c, flag_z);
    end
    step(0);                                    // JC 20
    n_chk++;
    if (rom_addr !== 8'h20) begin
      n_fail++;
      $display("FAIL jc_taken: addr=%h, want 20", rom_addr);
    end
    for (int i = 0; i < 6; i++) step(0);        // SUB, JZ, JC, LDI, NOT, OUT
    n_chk++;
    if ({out_port, out_stb, flag_c, flag_z} !== {8'hC3, 3'b101}) begin
      n_fail++;
      $display("FAIL out_value: out=%h stb=%b c=%b z=%b, want c3 1 0 1", out_port, out_stb, flag_c, flag_z);
    end
    step(0); step(0);                           // JMP FF, NOP at FF
    n_chk++;
    if (rom_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL pc_wrap: addr=%h, want 00", rom_addr);
    end
    step(0); step(0); step(0);                  // NOP, JZ 50 taken, HALT
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk); run = 1'($urandom_range(0, 1));
      n_chk++;
      if ({rom_addr, halted, out_stb} !== {8'h51, 2'b10}) begin
        n_fail++;
        $display("FAIL halt_hold: addr=%h halt=%b stb=%b, want 51 1 0", rom_addr, halted, out_stb);
      end
    end
  endtask

  task automatic test_reset_abort();
    clear_rom();
    rom[8'h00] = 8'h44;                         // OUT R1
    rom[8'h01] = 8'h14; rom[8'h02] = 8'h77;     // LDI R1,77
    rom[8'h03] = 8'h44;                         // OUT R1
    rom[8'h04] = 8'hF0;                         // HALT
    do_reset();
    step(0);
    run = 1'b1;
    @(posedge clk); @(negedge clk);             // DECODE
    @(posedge clk); @(negedge clk);             // OPER
    n_chk++;
    if (rom_addr !== 8'h02) begin
      n_fail++;
      $display("FAIL abort_oper: addr=%h, want 02", rom_addr);
    end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    n_chk++;
    if ({rom_addr, flag_c, flag_z, out_port, out_stb, halted} !== {8'h00, 12'd0}) begin
      n_fail++;
      $display("FAIL abort_reset: addr=%h c=%b z=%b out=%h stb=%b halt=%b, want 00 0 0 00 0 0", rom_addr, flag_c, flag_z, out_port, out_stb, halted);
    end
    model_init();
    step(0);                                    // OUT R1 must show 00
    n_chk++;
    if (out_port !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_no_write: out=%h, want 00", out_port);
    end
    step(0); step(0); step(0);                  // LDI, OUT 77, HALT
  endtask

  task automatic test_random();
    int idle;
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'($urandom);
      if (rom[i][7:4] == 4'hF) rom[i] = 8'h00;
    end
    do_reset();
    for (int n = 0; n < 150; n++) begin
      idle = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      step(idle);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    test_reset();
    test_run_hold();
    test_program();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Instruction sequencer that sits in front of the 8-bit ALU. It fetches instructions from a synchronous program ROM, decodes them and drives the ALU mode/select/operand inputs.
- It writes the ALU result T back into a 4x8 register file and latches Cf/Zf into a flag register. Conditional jumps read the latched flags.
- Forms the control half of the elementary CPU, with the ALU as the datapath half.

Parameters:
- PC_W, 8, program counter / ROM address width.
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- run  in  1  advance enable, sampled only in FETCH.
- rom_addr  out  PC_W  program address, equal to the PC register.
- rom_data  in  8  ROM word, valid one cycle after rom_addr.
- alu_M  out  1  ALU mode (0 = pass S, 1 = function per alu_se).
- alu_se  out  4  ALU function select.
- alu_S  out  8  ALU S operand.
- alu_D  out  8  ALU D operand.
- alu_T  in  8  ALU result.
- alu_Cf  in  1  ALU carry/borrow.
- alu_Zf  in  1  ALU zero.
- flag_c  out  1  latched carry.
- flag_z  out  1  latched zero.
- out_port  out  8  output register.
- out_stb  out  1  one-cycle pulse when out_port is loaded.
- halted  out  1  high in HALT.

Behaviour:
- Instruction byte: [7:4] opcode, [3:2] rd, [1:0] rs. Two-byte instructions carry an operand byte at PC+1.
- Reset (rst_n=0 at an edge) sets: PC=RESET_PC, state=FETCH, R0..R3=0, flag_c=flag_z=0, out_port=0, out_stb=0, halted=0. Reset aborts any instruction in flight with no register write.
- FSM states: FETCH, DECODE, OPER, EXEC, HALT.
  - FETCH: if run=1, go to DECODE; otherwise hold.
  - DECODE: IR<=rom_data, PC<=PC+1. Two-byte opcodes go to OPER; all others go to EXEC.
  - OPER: one wait cycle so the ROM can return the operand; then EXEC.
  - EXEC: execute the instruction; then FETCH, or HALT for opcode 1111.
  - HALT: absorbing until reset; halted=1.
- Latency: one-byte instructions take 3 cycles; two-byte instructions take 4 cycles.
- ALU drive outside EXEC: alu_M=0, alu_se=0000, alu_S=0, alu_D=0.
- ALU drive in EXEC, combinational from IR and registers. Results are captured at the EXEC edge.
  - 1001 ADD: M=1, se=1001, S=R[rs], D=R[rd]. R[rd]<=T; flags<=Cf,Zf.
  - 0110 SUB: M=1, se=0110, S=R[rs], D=R[rd]. R[rd]<=T (D-S); flags<=Cf,Zf.
  - 1011 AND: M=1, se=1011, S=R[rs], D=R[rd]. R[rd]<=T; flags<=Cf,Zf.
  - 0101 NOT: M=1, se=0101, D=R[rd]. R[rd]<=T; flags unchanged.
  - 1100 MOV: M=1, se=1100, S=R[rs]. R[rd]<=T.
  - 0100 OUT: M=1, se=0100, D=R[rd]. out_port<=T; out_stb=1 for exactly the next cycle.
  - 0001 LDI (two-byte): M=0, S=rom_data. R[rd]<=T.
  - 0010 JMP (two-byte): PC<=rom_data.
  - 0011 JC (two-byte): if flag_c, PC<=rom_data, else PC<=PC+1.
  - 0111 JZ (two-byte): if flag_z, PC<=rom_data, else PC<=PC+1.
  - LDI also sets PC<=PC+1 to skip the operand.
  - 1111 HALT.
  - 0000 and all other opcodes: NOP, no state change except the FSM.
- Flags change only on ADD/SUB/AND. Flags are taken verbatim from the ALU, including its rule that Zf is asserted only when Cf=0 and T=0.
- rd==rs is legal; the operand is read before the write.
- PC increments wrap modulo 2^PC_W.
- run=0 is honoured only in FETCH. An instruction already in flight always completes.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams (OP_ADD..OP_HALT).
  - ALU select constants (SE_ADD=1001, SE_SUB=0110, SE_AND=1011, SE_NOT=0101, SE_PASSD=0100, SE_PASSS=1100).
  - FSM state enum.
  - is_two_byte function.
- Sub-module: seq_regfile, a 4x8 file with two async read ports, one sync write port and synchronous reset.

Test Plan:
- Reset, then run=1 → rom_addr=00 and flag_c=flag_z=0. halted=0 throughout FETCH/DECODE/EXEC of a NOP, and the NOP takes 3 cycles.
- LDI R0,05; LDI R1,FB; ADD R1,R0 → R1=00, flag_c=1, flag_z=0. During the ADD EXEC: alu_M=1, alu_se=1001, alu_S=05, alu_D=FB.
- After the above, JC 20 → PC=20 after 4 cycles. Then SUB R2,R2 → flag_z=1, flag_c=0. Then JZ 40 → PC=40. Then JC 60 (not taken) → PC=operand address+1.
- LDI R3,3C; NOT R3; OUT R3 → out_port=C3 with a single-cycle out_stb. Flags unchanged by NOT.
- JMP FF; ROM[FF]=NOP → PC wraps to 00 after the NOP. HALT → halted=1 and the PC stays frozen for 10 cycles.
- Assert rst_n=0 during OPER of an LDI → no register write; PC=RESET_PC next cycle. run=0 in FETCH holds PC for 5 cycles.
